// File: rtl/half_adder_pkg.sv
// Shared constants for the registered multi-lane half adder.
package half_adder_pkg;

  localparam int unsigned LANES_MAX     = 64;
  localparam int unsigned CNT_W_DEFAULT = 16;

endpackage : half_adder_pkg

// File: rtl/half_adder_lane.sv
// Combinational 1-bit half adder cell.
module half_adder_lane (
  input  logic a,
  input  logic b,
  output logic sum_c,
  output logic carry_c
);

  assign sum_c   = a ^ b;
  assign carry_c = a & b;

endmodule : half_adder_lane

// File: rtl/half_adder.sv
// Registered multi-lane half adder with valid qualifier and a saturating
// carry-event counter for datapath debug.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             valid_in,
  input  logic             clr_cnt,
  output logic [LANES-1:0] sum,
  output logic [LANES-1:0] carry,
  output logic             valid_out,
  output logic             carry_any,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LANES-1:0] sum_c;
  logic [LANES-1:0] carry_c;
  logic             carry_any_c;
  logic             cnt_inc_c;

  // Independent lanes; no carry ripples between them.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    half_adder_lane u_lane (
      .a       (a[i]),
      .b       (b[i]),
      .sum_c   (sum_c[i]),
      .carry_c (carry_c[i])
    );
  end

  assign carry_any_c = |carry_c;
  assign cnt_inc_c   = valid_in && carry_any_c && (carry_cnt != CNT_MAX);

  // Result registers load only on accepted cycles, so unqualified operands never leak.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry     <= '0;
      valid_out <= 1'b0;
      carry_any <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        sum       <= sum_c;
        carry     <= carry_c;
        carry_any <= carry_any_c;
      end
    end
  end

  // Clear wins over increment; counter sticks at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (clr_cnt) begin
      carry_cnt <= '0;
    end else if (cnt_inc_c) begin
      carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Directed and model-based checks for half_adder in 1-, 4- and 8-lane builds.
module tb_half_adder;

  logic clk;
  logic rst;

  // 1-lane default build
  logic        a1, b1, v1, c1;
  logic        s1, k1, vo1, ka1;
  logic [15:0] n1;

  // 4-lane build with a 2-bit counter
  logic [3:0]  a4, b4, s4, k4;
  logic        v4, c4, vo4, ka4;
  logic [1:0]  n4;

  // 8-lane build for random checking
  logic [7:0]  a8, b8, s8, k8;
  logic        v8, c8, vo8, ka8;
  logic [15:0] n8;

  int passed;
  int total;

  half_adder u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .valid_in(v1), .clr_cnt(c1),
    .sum(s1), .carry(k1), .valid_out(vo1), .carry_any(ka1), .carry_cnt(n1)
  );

  half_adder #(.LANES(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .valid_in(v4), .clr_cnt(c4),
    .sum(s4), .carry(k4), .valid_out(vo4), .carry_any(ka4), .carry_cnt(n4)
  );

  half_adder #(.LANES(8)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .valid_in(v8), .clr_cnt(c8),
    .sum(s8), .carry(k8), .valid_out(vo8), .carry_any(ka8), .carry_cnt(n8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic k;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[4];
    logic [7:0]  ms, mk;
    logic        mvo, mka;
    logic [15:0] mn;

    passed = 0;
    total  = 0;
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; c1 = 1'b0;
    a4 = '0;   b4 = '0;   v4 = 1'b0; c4 = 1'b0;
    a8 = '0;   b8 = '0;   v8 = 1'b0; c8 = 1'b0;

    vecs[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, k: 1'b0};
    vecs[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, k: 1'b0};
    vecs[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, k: 1'b0};
    vecs[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, k: 1'b1};

    step();
    step();
    chk("rst_sum",   64'(s1),  64'd0);
    chk("rst_carry", 64'(k1),  64'd0);
    chk("rst_vo",    64'(vo1), 64'd0);
    chk("rst_any",   64'(ka1), 64'd0);
    chk("rst_cnt",   64'(n1),  64'd0);
    rst = 1'b0;

    // Truth table at 5-cycle spacing.
    for (int i = 0; i < 4; i++) begin
      a1 = vecs[i].a; b1 = vecs[i].b; v1 = 1'b1;
      step();
      chk($sformatf("tt%0d_sum", i),   64'(s1),  64'(vecs[i].s));
      chk($sformatf("tt%0d_carry", i), 64'(k1),  64'(vecs[i].k));
      chk($sformatf("tt%0d_vo", i),    64'(vo1), 64'd1);
      chk($sformatf("tt%0d_any", i),   64'(ka1), 64'(vecs[i].k));
      v1 = 1'b0;
      for (int j = 0; j < 4; j++) step();
      chk($sformatf("tt%0d_hold_sum", i),   64'(s1),  64'(vecs[i].s));
      chk($sformatf("tt%0d_hold_carry", i), 64'(k1),  64'(vecs[i].k));
      chk($sformatf("tt%0d_hold_vo", i),    64'(vo1), 64'd0);
    end
    chk("tt_cnt", 64'(n1), 64'd1);

    // Unqualified 11 after sum=1 must not disturb anything.
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    step();
    chk("pre_hold_sum", 64'(s1), 64'd1);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
    step();
    chk("hold_sum",   64'(s1),  64'd1);
    chk("hold_carry", 64'(k1),  64'd0);
    chk("hold_vo",    64'(vo1), 64'd0);
    chk("hold_cnt",   64'(n1),  64'd1);

    // X operands while not valid.
    a1 = 1'bx; b1 = 1'bz;
    step();
    chk("x_sum",   64'(s1),  64'd1);
    chk("x_carry", 64'(k1),  64'd0);
    chk("x_any",   64'(ka1), 64'd0);
    chk("x_cnt",   64'(n1),  64'd1);

    // Build carry=1, cnt=3, then reset mid-stream with valid high.
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    step();
    step();
    chk("pre_rst_carry", 64'(k1), 64'd1);
    chk("pre_rst_cnt",   64'(n1), 64'd3);
    rst = 1'b1; c1 = 1'b0;
    step();
    chk("mid_rst_sum",   64'(s1),  64'd0);
    chk("mid_rst_carry", 64'(k1),  64'd0);
    chk("mid_rst_vo",    64'(vo1), 64'd0);
    chk("mid_rst_any",   64'(ka1), 64'd0);
    chk("mid_rst_cnt",   64'(n1),  64'd0);
    rst = 1'b0; a1 = 1'b0; b1 = 1'b1;
    step();
    chk("post_rst_sum",   64'(s1),  64'd1);
    chk("post_rst_carry", 64'(k1),  64'd0);
    chk("post_rst_vo",    64'(vo1), 64'd1);
    v1 = 1'b0;

    // Four lanes.
    a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
    step();
    chk("l4_sum",   64'(s4),  64'h6);
    chk("l4_carry", 64'(k4),  64'h8);
    chk("l4_any",   64'(ka4), 64'd1);
    chk("l4_cnt",   64'(n4),  64'd1);
    a4 = 4'b0101; b4 = 4'b1010;
    step();
    chk("l4b_sum",   64'(s4),  64'hf);
    chk("l4b_carry", 64'(k4),  64'h0);
    chk("l4b_any",   64'(ka4), 64'd0);
    chk("l4b_cnt",   64'(n4),  64'd1);

    // Saturation of a 2-bit counter, then clear beating an increment.
    v4 = 1'b0; c4 = 1'b1;
    step();
    chk("sat_clr0", 64'(n4), 64'd0);
    c4 = 1'b0; a4 = 4'b1111; b4 = 4'b1111; v4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("sat_cnt%0d", i), 64'(n4), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    c4 = 1'b1;
    step();
    chk("clr_vs_inc_cnt",   64'(n4), 64'd0);
    chk("clr_vs_inc_carry", 64'(k4), 64'hf);
    c4 = 1'b0;
    step();
    chk("post_clr_cnt", 64'(n4), 64'd1);
    v4 = 1'b0;

    // Random 8-lane run against a reference model.
    c8 = 1'b1;
    step();
    c8 = 1'b0;
    ms = s8; mk = k8; mka = ka8; mn = 16'd0;
    chk("rnd_start_cnt", 64'(n8), 64'd0);
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
      c8 = ($urandom_range(0, 63) == 0);
      mvo = v8;
      if (v8) begin
        ms  = a8 ^ b8;
        mk  = a8 & b8;
        mka = (mk != 8'd0);
      end
      if (c8) mn = 16'd0;
      else if (v8 && ((a8 & b8) != 8'd0)) mn = mn + 16'd1;
      step();
      chk($sformatf("rnd%0d_sum", i),   64'(s8),  64'(ms));
      chk($sformatf("rnd%0d_carry", i), 64'(k8),  64'(mk));
      chk($sformatf("rnd%0d_excl", i),  64'(s8 & k8), 64'd0);
      chk($sformatf("rnd%0d_vo", i),    64'(vo8), 64'(mvo));
      chk($sformatf("rnd%0d_any", i),   64'(ka8), 64'(mka));
      chk($sformatf("rnd%0d_cnt", i),   64'(n8),  64'(mn));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_half_adder

// File: doc/half_adder.md
Name: half_adder

Overview:
- Registered multi-lane half adder: each lane computes sum = a XOR b and carry = a AND b for one-bit operands.
- Default configuration (LANES=1) is the classic 1-bit half adder with a clock and a synchronous reset around it.
- Used as a leaf arithmetic cell that full adders and counter datapaths compose from.
- Includes an input-valid qualifier and a saturating carry-event counter for datapath debug.

Parameters:
- LANES, 1, number of independent 1-bit half-adder lanes (1..64).
- CNT_W, 16, width of the saturating carry-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  LANES  operand A; bit i feeds lane i.
- b  input  LANES  operand B; bit i feeds lane i.
- valid_in  input  1  qualifies a/b; when low, outputs hold.
- sum  output  LANES  registered a XOR b per lane.
- carry  output  LANES  registered a AND b per lane.
- valid_out  output  1  registered copy of valid_in.
- carry_any  output  1  registered OR-reduction of the per-lane carries.
- carry_cnt  output  CNT_W  saturating count of accepted cycles with carry_any=1.
- clr_cnt  input  1  synchronous clear of carry_cnt only.

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high. There is no asynchronous path.
- Reset: on a rising clk edge with rst=1, the following all go to 0 the same edge:
  - sum, carry, valid_out, carry_any, carry_cnt.
  - rst has priority over valid_in and clr_cnt.
- Latency: 1 cycle. Values of a/b sampled at edge N appear on sum/carry at edge N (visible after edge N), and stay stable until the next accepted sample.
- valid_in=1: sum[i] <= a[i]^b[i], carry[i] <= a[i]&b[i], carry_any <= |(a&b), valid_out <= 1.
- valid_in=0: sum, carry and carry_any hold their previous values; valid_out <= 0.
- Truth table per lane (a,b -> sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Lane invariant: sum[i] and carry[i] are never both 1.
- Lanes are fully independent; there is no carry propagation between lanes.
- carry_cnt:
  - Increments by 1 on each edge where valid_in=1 and |(a&b)=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 sets it to 0. clr_cnt takes priority over an increment in the same cycle.
- X/Z on a or b while valid_in=0 must not affect any output.
- Reset mid-stream: the output deasserts on the next edge; the first post-reset accepted sample follows normal 1-cycle latency.

Decomposition:
- Shared package: LANES_MAX=64 and the default CNT_W constant; no typedefs needed.
- One natural sub-module: half_adder_lane (purely combinational 1-bit sum/carry). It is instantiated LANES times via generate; registers and the counter stay in the top.

Test Plan:
- Reset, then LANES=1, valid_in=1, apply (a,b) = 00, 01, 10, 11 at 5-cycle spacing. Required (sum,carry) one cycle after each: 0,0 / 1,0 / 1,0 / 0,1. carry_cnt ends at 1.
- Apply a=1, b=1 with valid_in=0 after sum=1 -> sum and carry hold at 1,0; valid_out=0; carry_cnt unchanged.
- Assert rst while carry=1 and carry_cnt=3 -> next edge: all outputs 0. Next accepted sample 01 -> sum=1 one cycle later.
- CNT_W=2, hold a=b=1 with valid_in=1 for 6 cycles -> carry_cnt goes 1, 2, 3, 3, 3, 3. clr_cnt asserted with a=b=1 -> carry_cnt=0.
- LANES=4, a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000, carry_any=1. Then a=4'b0101, b=4'b1010 -> carry=0, carry_any=0.
- Randomized 1000 cycles (LANES=8) against a model -> sum==a^b, carry==a&b delayed one accepted cycle. Check (sum&carry)==0 always.
